sisc_prog_loader: RTL and testbench

Program loader that fills the SISC processor's instruction/data memory before execution. It accepts a big-endian byte stream over a valid/ready handshake and packs it into 32-bit words. Words are written to consecutive memory addresses starting at 0. When the final word is written, the loader releases the processor's reset. It is the writer side of the `MEM` array that the processor's fetch stage reads.

---
 rtl/sisc_prog_loader.sv | 154 +++++++++++++++
 tb/tb_sisc_prog_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_prog_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words, writes them from address 0
// and releases the processor reset once the program is in. Optional macro: LOADER_CHECKSUM_EN.
module sisc_prog_loader #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_byte,
  input  logic                in_last,
  output logic                mem_we,
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                cpu_reset,
  output logic                done,
  output logic                err,
  output logic [ADDRSIZE:0]   word_count
);

  localparam logic [ADDRSIZE:0] MemWords = {1'b1, {ADDRSIZE{1'b0}}};

  typedef enum logic [2:0] {
    StLoad,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StError
  } state_e;

  state_e              state;
  logic [ADDRSIZE-1:0] addr_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         shift_q;
  logic                last_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic accept;
  logic full;

  assign accept = in_valid && in_ready;
  // Once MemWords words are in, any further program byte is an overflow.
  assign full   = (word_count == MemWords);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StLoad;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        StLoad: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (full || (in_last && (byte_cnt_q != 2'd3))) begin
              state     <= StError;
              in_ready  <= 1'b0;
              err       <= 1'b1;
              cpu_reset <= 1'b1;
              done      <= 1'b0;
            end else begin
              shift_q    <= {shift_q[15:0], in_byte};
              byte_cnt_q <= byte_cnt_q + 2'd1;
              last_q     <= in_last;
`ifdef LOADER_CHECKSUM_EN
              csum_q     <= csum_q ^ in_byte;
`endif
              if (byte_cnt_q == 2'd3) begin
                state     <= StWrite;
                in_ready  <= 1'b0;
                mem_we    <= 1'b1;
                mem_addr  <= addr_q;
                mem_wdata <= WIDTH'({shift_q, in_byte});
              end
            end
          end
        end

        StWrite: begin
          addr_q <= addr_q + 1'b1;
          if (!full) begin
            word_count <= word_count + 1'b1;
          end
          if (last_q) begin
`ifdef LOADER_CHECKSUM_EN
            state    <= StCsum;
            in_ready <= 1'b1;
`else
            state     <= StDone;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
`endif
          end else begin
            state    <= StLoad;
            in_ready <= 1'b1;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        StCsum: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_byte == csum_q) begin
              state     <= StDone;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state     <= StError;
              err       <= 1'b1;
              cpu_reset <= 1'b1;
            end
          end
        end
`endif

        StDone: begin
          in_ready <= 1'b0;
        end

        StError: begin
          in_ready <= 1'b0;
        end

        default: begin
          state     <= StError;
          in_ready  <= 1'b0;
          err       <= 1'b1;
          cpu_reset <= 1'b1;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_prog_loader.sv
// Scoreboard bench for sisc_prog_loader: a full-size instance and an ADDRSIZE=2 instance.
module tb_sisc_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic        va = 1'b0, la = 1'b0;
  logic [7:0]  ba = '0;
  logic        ra, wea, cra, donea, erra;
  logic [11:0] addra;
  logic [31:0] wda;
  logic [12:0] wca;

  logic        vb = 1'b0, lb = 1'b0;
  logic [7:0]  bb = '0;
  logic        rb, web, crb, doneb, errb;
  logic [1:0]  addrb;
  logic [31:0] wdb;
  logic [2:0]  wcb;

  sisc_prog_loader #(.WIDTH(32), .ADDRSIZE(12)) dut (
    .clk(clk), .reset(reset), .in_valid(va), .in_ready(ra), .in_byte(ba), .in_last(la),
    .mem_we(wea), .mem_addr(addra), .mem_wdata(wda), .cpu_reset(cra), .done(donea),
    .err(erra), .word_count(wca)
  );

  sisc_prog_loader #(.WIDTH(32), .ADDRSIZE(2)) dut_small (
    .clk(clk), .reset(reset), .in_valid(vb), .in_ready(rb), .in_byte(bb), .in_last(lb),
    .mem_we(web), .mem_addr(addrb), .mem_wdata(wdb), .cpu_reset(crb), .done(doneb),
    .err(errb), .word_count(wcb)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [7:0]  prog [12] = '{8'h2A, 8'h00, 8'h00, 8'h01, 8'hB8, 8'h00, 8'h50, 8'h00,
                             8'hA0, 8'h00, 8'h00, 8'h00};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: every write strobe is popped against the expected write queue.
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_unexpected_write: got 0x%0h@0x%0h, expected no write", wda, addra);
      end else begin
        check("a_write", {20'h0, addra, wda}, exp_a.pop_front());
        check("a_ready_low_in_write", 64'(ra), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (web === 1'b1) begin
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_unexpected_write: got 0x%0h@0x%0h, expected no write", wdb, addrb);
      end else begin
        check("b_write", {30'h0, addrb, wdb}, exp_b.pop_front());
        check("b_ready_low_in_write", 64'(rb), 64'd0);
      end
    end
  end

  task automatic send(input int d, input logic [7:0] b, input logic l);
    bit ok = 0;
    if (d == 0) begin va = 1'b1; ba = b; la = l; end
    else begin vb = 1'b1; bb = b; lb = l; end
    for (int i = 0; i < 50 && !ok; i++) begin
      if (((d == 0) ? ra : rb) === 1'b1) ok = 1;
      @(negedge clk);
    end
    va = 1'b0; la = 1'b0; vb = 1'b0; lb = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: byte 0x%0h not accepted, expected acceptance", b);
    end
  endtask

  task automatic send_prog(input int n, input int last_idx, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, prog[i], i == last_idx);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_good_load(input string tag);
    for (int i = 0; i < 3; i++) check({tag, "_done"}, 64'(donea), 64'd1);
    check({tag, "_cpu_reset"}, 64'(cra), 64'd0);
    check({tag, "_word_count"}, 64'(wca), 64'd3);
    check({tag, "_err"}, 64'(erra), 64'd0);
    check({tag, "_in_ready"}, 64'(ra), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] wb [4];
    wb = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(ra), 64'd0);
    check("rst_mem_we", 64'(wea), 64'd0);
    check("rst_mem_addr", 64'(addra), 64'd0);
    check("rst_mem_wdata", 64'(wda), 64'd0);
    check("rst_cpu_reset", 64'(cra), 64'd1);
    check("rst_done", 64'(donea), 64'd0);
    check("rst_err", 64'(erra), 64'd0);
    check("rst_word_count", 64'(wca), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(ra), 64'd1);

    // Three-word program, back to back
    exp_a.push_back({32'd0, 32'h2A000001});
    exp_a.push_back({32'd1, 32'hB8005000});
    exp_a.push_back({32'd2, 32'hA0000000});
    send_prog(12, 11, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("csum_wait_done", 64'(donea), 64'd0);
    send(0, 8'h63, 1'b0);
`endif
    repeat (2) @(negedge clk);
    expect_good_load("load3");
    // Extra input after DONE must be ignored
    va = 1'b1; ba = 8'hFF;
    repeat (6) @(negedge clk);
    va = 1'b0;
    check("done_ignores_input_wc", 64'(wca), 64'd3);

    // Same program with in_valid gaps
    pulse_reset();
    exp_a.push_back({32'd0, 32'h2A000001});
    exp_a.push_back({32'd1, 32'hB8005000});
    exp_a.push_back({32'd2, 32'hA0000000});
    send_prog(12, 11, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send(0, 8'h63, 1'b0);
`endif
    repeat (2) @(negedge clk);
    expect_good_load("gaps");

    // in_last on the 6th byte: partial word aborts
    pulse_reset();
    exp_a.push_back({32'd0, 32'h2A000001});
    send_prog(6, 5, 1'b0);
    repeat (2) @(negedge clk);
    check("partial_err", 64'(erra), 64'd1);
    check("partial_cpu_reset", 64'(cra), 64'd1);
    check("partial_in_ready", 64'(ra), 64'd0);
    check("partial_done", 64'(donea), 64'd0);
    check("partial_word_count", 64'(wca), 64'd1);

    // Reset mid-stream, then a single zero word
    pulse_reset();
    exp_a.push_back({32'd0, 32'h2A000001});
    send_prog(6, -1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_word_count", 64'(wca), 64'd0);
    check("midrst_cpu_reset", 64'(cra), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    exp_a.push_back({32'd0, 32'h00000000});
    for (int i = 0; i < 4; i++) send(0, 8'h00, i == 3);
`ifdef LOADER_CHECKSUM_EN
    send(0, 8'h00, 1'b0);
`endif
    repeat (2) @(negedge clk);
    check("midrst_word_count_after", 64'(wca), 64'd1);
    check("midrst_done", 64'(donea), 64'd1);
    check("midrst_cpu_reset_after", 64'(cra), 64'd0);

    // Overflow on the 4-word instance
    pulse_reset();
    for (int w = 0; w < 4; w++) begin
      exp_b.push_back({32'(w), wb[w]});
      for (int k = 0; k < 4; k++) send(1, wb[w][31-8*k -: 8], 1'b0);
    end
    repeat (2) @(negedge clk);
    check("ovf_wc_full", 64'(wcb), 64'd4);
    check("ovf_no_err_yet", 64'(errb), 64'd0);
    send(1, 8'h11, 1'b0);
    @(negedge clk);
    check("ovf_err", 64'(errb), 64'd1);
    check("ovf_word_count", 64'(wcb), 64'd4);
    check("ovf_cpu_reset", 64'(crb), 64'd1);
    check("ovf_in_ready", 64'(rb), 64'd0);
    check("ovf_done", 64'(doneb), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    pulse_reset();
    exp_a.push_back({32'd0, 32'h11223344});
    send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b0); send(0, 8'h44, 1'b1);
    send(0, 8'h44, 1'b0);
    @(negedge clk);
    check("csum_good_done", 64'(donea), 64'd1);
    check("csum_good_cpu_reset", 64'(cra), 64'd0);
    pulse_reset();
    exp_a.push_back({32'd0, 32'h11223344});
    send(0, 8'h11, 1'b0); send(0, 8'h22, 1'b0); send(0, 8'h33, 1'b0); send(0, 8'h44, 1'b1);
    send(0, 8'h45, 1'b0);
    @(negedge clk);
    check("csum_bad_err", 64'(erra), 64'd1);
    check("csum_bad_cpu_reset", 64'(cra), 64'd1);
    check("csum_bad_done", 64'(donea), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("a_writes_all_seen", 64'(exp_a.size()), 64'd0);
    check("b_writes_all_seen", 64'(exp_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
